// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: signed/unsigned quotient + remainder with ALU-style status.
// Latency: WIDTH+2 cycles from the accepting edge to out_valid; 1 cycle for divide-by-zero and signed overflow.
// Backpressure: single operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   in_valid/in_ready           operation handshake; signed_op, operand1 (dividend), operand2 (divisor)
//   out_valid/out_ready         result handshake; result (quotient), remainder, statusOut {NEG,ZERO,CARRY,OVERFLOW}
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic [3:0]       statusOut
);

    // Status flag bit positions shared with the ALU.
    localparam int ST_NEG      = 3;
    localparam int ST_ZERO     = 2;
    localparam int ST_CARRY    = 1;
    localparam int ST_OVERFLOW = 0;

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo;      // dividend shifts out the top while quotient bits shift in
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] acc;      // partial remainder, always < dvs
    logic             neg_q;
    logic             neg_r;

    logic             div_zero;
    logic             sgn_ovf;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;
    logic [WIDTH-1:0] most_neg;

    function automatic logic [3:0] mk_status(input logic [WIDTH-1:0] q,
                                             input logic carry,
                                             input logic ovf);
        logic [3:0] st;
        st              = 4'b0000;
        st[ST_NEG]      = q[WIDTH-1];
        st[ST_ZERO]     = (q == '0);
        st[ST_CARRY]    = carry;
        st[ST_OVERFLOW] = ovf;
        return st;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        most_neg            = '0;
        most_neg[WIDTH-1]   = 1'b1;
    end

    assign div_zero = (operand2 == '0);
    assign sgn_ovf  = signed_op && (operand1 == most_neg) && (operand2 == '1);

    // Because acc < dvs is invariant, trial < 2*dvs, so the top bit of diff is a
    // reliable borrow flag for the restoring comparison.
    assign trial = {acc, quo[WIDTH-1]};
    assign diff  = trial - {1'b0, dvs};
    assign take  = ~diff[WIDTH];

    assign fix_q = neg_q ? (~quo + 1'b1) : quo;
    assign fix_r = neg_r ? (~acc + 1'b1) : acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (div_zero || sgn_ovf) state_nxt = DONE;
                    else                     state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            end
            FIX:  state_nxt = DONE;
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            remainder <= '0;
            statusOut <= '0;
            cnt       <= '0;
            quo       <= '0;
            dvs       <= '0;
            acc       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (div_zero) begin
                            result    <= '1;
                            remainder <= operand1;
                            statusOut <= mk_status('1, 1'b1, 1'b0);
                        end else if (sgn_ovf) begin
                            result    <= operand1;
                            remainder <= '0;
                            statusOut <= mk_status(operand1, 1'b0, 1'b1);
                        end else begin
                            // Magnitude of the most-negative value is 2^(WIDTH-1), which
                            // is representable as an unsigned WIDTH-bit number.
                            quo   <= (signed_op && operand1[WIDTH-1]) ? (~operand1 + 1'b1) : operand1;
                            dvs   <= (signed_op && operand2[WIDTH-1]) ? (~operand2 + 1'b1) : operand2;
                            acc   <= '0;
                            cnt   <= '0;
                            neg_q <= signed_op && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
                            neg_r <= signed_op && operand1[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    quo <= {quo[WIDTH-2:0], take};
                    acc <= take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    result    <= fix_q;
                    remainder <= fix_r;
                    statusOut <= mk_status(fix_q, 1'b0, 1'b0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH = 8): directed literals plus randomized operations vs an arithmetic model.
// Latency: checks WIDTH+2 / 1 cycle result latency and hold/return-to-idle timing.
// Backpressure: exercises out_ready stalls with in_valid asserted and a mid-calculation reset.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         signed_op;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic [3:0]   statusOut;

    int checks = 0;
    int errors = 0;

    logic [19:0]  exp_res;      // {quotient, remainder, status}
    logic         exp_pending = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .signed_op (signed_op),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .remainder (remainder),
        .statusOut (statusOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Status layout {NEG, ZERO, CARRY, OVERFLOW}; quotient truncates toward zero,
    // remainder takes the sign of the dividend (native int / and % semantics).
    function automatic logic [19:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int ia, ib, iq, ir;
        logic [W-1:0] q, r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        if (b == 0) begin
            q = '1; r = a; c = 1'b1;
        end else if (s && a == 8'h80 && b == 8'hFF) begin
            q = a; r = '0; v = 1'b1;
        end else if (s) begin
            ia = $signed(a);
            ib = $signed(b);
            iq = ia / ib;
            ir = ia % ib;
            q  = iq[W-1:0];
            r  = ir[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r, q[W-1], (q == 0), c, v};
    endfunction

    // Every cycle a result is presented it must match the model of the accepted op.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("spurious_out_valid", {63'd0, exp_pending}, 64'd1);
            chk("result", result, exp_res[19:12]);
            chk("remainder", remainder, exp_res[11:4]);
            chk("status", statusOut, exp_res[3:0]);
            chk("in_ready_in_done", in_ready, 0);
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int hold, input logic lit_en, input logic [19:0] lit);
        int lat;
        int k;
        logic [19:0] m;
        logic special;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_before_issue", in_ready, 1);
        operand1  = a;
        operand2  = b;
        signed_op = s;
        in_valid  = 1'b1;
        @(posedge clk);
        m           = model(a, b, s);
        exp_res     = m;
        exp_pending = 1'b1;
        special     = (b == 0) || (s && a == 8'h80 && b == 8'hFF);
        #1;
        // Inputs change and stay valid while busy; none of this may disturb the op.
        operand1  = $urandom;
        operand2  = $urandom;
        signed_op = $urandom;
        in_valid  = 1'b1;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, special ? 1 : W + 2);
        if (lit_en) begin
            chk("lit_result", result, lit[19:12]);
            chk("lit_remainder", remainder, lit[11:4]);
            chk("lit_status", statusOut, lit[3:0]);
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
            operand1 = $urandom;
            operand2 = $urandom;
        end
        out_ready = 1'b1;
        @(posedge clk);
        exp_pending = 1'b0;
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("ret_idle_in_ready", in_ready, 1);
        chk("ret_idle_out_valid", out_valid, 0);
        chk("retain_result", result, m[19:12]);
        chk("retain_remainder", remainder, m[11:4]);
    endtask

    task automatic reset_mid_calc();
        @(negedge clk);
        operand1  = 8'd200;
        operand2  = 8'd3;
        signed_op = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        exp_pending = 1'b0;     // aborted op must never present a result
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b1;
        operand1  = 8'd77;
        operand2  = 8'd5;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_result", result, 0);
        chk("rst_mid_remainder", remainder, 0);
        chk("rst_mid_status", statusOut, 0);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        repeat (15) begin
            @(posedge clk);
            #1;
            chk("abort_no_out_valid", out_valid, 0);
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic s;
        int sel;

        rst       = 1'b1;
        in_valid  = 1'b1;   // must not be taken on reset edges
        out_ready = 1'b0;
        signed_op = 1'b0;
        operand1  = 8'd9;
        operand2  = 8'd2;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("reset_result", result, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_status", statusOut, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);

        // Hand-computed values pinning the model itself.
        chk("model_100_7", model(8'd100, 8'd7, 1'b0), {8'd14, 8'd2, 4'b0000});
        chk("model_f9_2_s", model(8'hF9, 8'h02, 1'b1), {8'hFD, 8'hFF, 4'b1000});
        chk("model_80_ff_s", model(8'h80, 8'hFF, 1'b1), {8'h80, 8'h00, 4'b1001});

        // Directed operations; 100/7 also held for 5 cycles with new ops pending,
        // and is followed immediately by the next operation.
        run_op(8'd100, 8'd7, 1'b0, 5, 1'b1, {8'd14, 8'd2, 4'b0000});
        run_op(8'hF9, 8'h02, 1'b1, 0, 1'b1, {8'hFD, 8'hFF, 4'b1000});
        run_op(8'hF9, 8'h02, 1'b0, 1, 1'b1, {8'h7C, 8'h01, 4'b0000});
        run_op(8'h55, 8'h00, 1'b0, 0, 1'b1, {8'hFF, 8'h55, 4'b1010});
        run_op(8'h55, 8'h00, 1'b1, 2, 1'b1, {8'hFF, 8'h55, 4'b1010});
        run_op(8'h80, 8'hFF, 1'b1, 0, 1'b1, {8'h80, 8'h00, 4'b1001});
        run_op(8'h03, 8'h09, 1'b0, 0, 1'b1, {8'h00, 8'h03, 4'b0100});
        run_op(8'h80, 8'h01, 1'b1, 0, 1'b1, {8'h80, 8'h00, 4'b1000});

        reset_mid_calc();
        run_op(8'd200, 8'd3, 1'b0, 0, 1'b1, {8'd66, 8'd2, 4'b0000});

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            s   = $urandom;
            if (sel == 0) b = 8'h00;
            if (sel == 1) begin
                a = 8'h80; b = 8'hFF; s = 1'b1;
            end
            if (sel == 2) b = $urandom_range(1, 3);
            run_op(a, b, s, $urandom_range(0, 3), 1'b0, 20'd0);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
